// File: rtl/xbus_arb.sv
// xbus request/grant arbiter.
// m0/m2/m3 rotate round-robin in the order 0 -> 2 -> 3 -> 0.
// m1 (instruction fetch) owns the bus whenever nobody else asks for it,
// and is forced onto the bus after MAX_WAIT denied cycles.
// A locked tenure lasts at most MAX_LOCK consecutive cycles.
module xbus_arb #(
  parameter int MAX_WAIT = 8,
  parameter int MAX_LOCK = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_i,
  input  logic [3:0] lock_i,
  output logic [3:0] grant_o,
  output logic [1:0] gnt_id_o,
  output logic       busy_o,
  output logic [3:0] hold_o
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
  localparam logic [7:0] LOCK_LIM = 8'(MAX_LOCK - 1);

  logic [1:0] rr_last;
  logic [1:0] rr_nxt;
  logic [3:0] wait_cnt;
  logic [3:0] wait_nxt;
  logic [7:0] lock_cnt;
  logic [7:0] lock_nxt;
  logic       gnt_vld;
  logic [1:0] id_nxt;
  logic [1:0] ord0;
  logic [1:0] ord1;
  logic [1:0] ord2;
  logic       retain;

  // Pick the next owner (first matching rule wins) and update the tenure/wait counters.
  always_comb begin
    gnt_vld  = 1'b0;
    id_nxt   = 2'd0;
    rr_nxt   = rr_last;
    lock_nxt = 8'd0;
    wait_nxt = 4'd0;
    ord0     = 2'd0;
    ord1     = 2'd2;
    ord2     = 2'd3;

    // search starts just after the last round-robin winner
    case (rr_last)
      2'd0: begin ord0 = 2'd2; ord1 = 2'd3; ord2 = 2'd0; end
      2'd2: begin ord0 = 2'd3; ord1 = 2'd0; ord2 = 2'd2; end
      default: begin ord0 = 2'd0; ord1 = 2'd2; ord2 = 2'd3; end
    endcase

    retain = busy_o && req_i[gnt_id_o] && lock_i[gnt_id_o] && (lock_cnt < LOCK_LIM);

    if (retain) begin
      gnt_vld = 1'b1;
      id_nxt  = gnt_id_o;
    end else if (req_i[1] && (wait_cnt == WAIT_MAX)) begin
      gnt_vld = 1'b1;
      id_nxt  = 2'd1;
    end else if (req_i[ord0]) begin
      gnt_vld = 1'b1;
      id_nxt  = ord0;
      rr_nxt  = ord0;
    end else if (req_i[ord1]) begin
      gnt_vld = 1'b1;
      id_nxt  = ord1;
      rr_nxt  = ord1;
    end else if (req_i[ord2]) begin
      gnt_vld = 1'b1;
      id_nxt  = ord2;
      rr_nxt  = ord2;
    end else if (req_i[1]) begin
      gnt_vld = 1'b1;
      id_nxt  = 2'd1;
    end

    // saturating at the limit keeps long unlocked runs from wrapping back under it
    if (gnt_vld && busy_o && (id_nxt == gnt_id_o)) begin
      lock_nxt = (lock_cnt == LOCK_LIM) ? lock_cnt : lock_cnt + 8'd1;
    end

    if (!req_i[1] || (gnt_vld && (id_nxt == 2'd1))) begin
      wait_nxt = 4'd0;
    end else if (wait_cnt < WAIT_MAX) begin
      wait_nxt = wait_cnt + 4'd1;
    end else begin
      wait_nxt = wait_cnt;
    end
  end

  // Register the grant and arbitration state; reset drops any tenure in progress.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      grant_o  <= 4'b0000;
      gnt_id_o <= 2'd0;
      busy_o   <= 1'b0;
      rr_last  <= 2'd3;
      wait_cnt <= 4'd0;
      lock_cnt <= 8'd0;
    end else begin
      grant_o  <= gnt_vld ? (4'b0001 << id_nxt) : 4'b0000;
      gnt_id_o <= gnt_vld ? id_nxt : 2'd0;
      busy_o   <= gnt_vld;
      rr_last  <= rr_nxt;
      wait_cnt <= wait_nxt;
      lock_cnt <= lock_nxt;
    end
  end

  assign hold_o = req_i & ~grant_o;

endmodule

// File: tb/tb_xbus_arb.sv
// Bench for xbus_arb: directed scenarios plus a randomized run, all
// checked against a rule-level reference model of the arbiter.
module tb_xbus_arb;

  localparam int MAX_WAIT = 8;
  localparam int MAX_LOCK = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_i;
  logic [3:0] lock_i;
  logic [3:0] grant_o;
  logic [1:0] gnt_id_o;
  logic       busy_o;
  logic [3:0] hold_o;

  int n_vec = 0;
  int n_err = 0;

  // reference model: owner index (-1 idle), consecutive re-grants, m1 denial count, last rr winner
  int m_owner   = -1;
  int m_run     = 0;
  int m_wait    = 0;
  int m_last_rr = 3;
  logic [3:0] dec_req;

  always #5 clk = ~clk;

  xbus_arb #(.MAX_WAIT(MAX_WAIT), .MAX_LOCK(MAX_LOCK)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_i),
    .lock_i   (lock_i),
    .grant_o  (grant_o),
    .gnt_id_o (gnt_id_o),
    .busy_o   (busy_o),
    .hold_o   (hold_o)
  );

  function automatic logic [3:0] exp_grant();
    return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
  endfunction

  function automatic logic [1:0] exp_id();
    return (m_owner < 0) ? 2'd0 : 2'(m_owner);
  endfunction

  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic rst);
    @(negedge clk);
    req_i  = r;
    lock_i = l;
    rst_n  = rst;
    #1;
  endtask

  // advance the model with the currently driven inputs, then let the DUT take the edge
  task automatic tick();
    int nxt;
    int pos;
    int cand;
    int ring[3] = '{0, 2, 3};
    dec_req = req_i;
    if (rst_n) begin
      m_owner   = -1;
      m_run     = 0;
      m_wait    = 0;
      m_last_rr = 3;
    end else begin
      nxt = -1;
      if (m_owner >= 0 && req_i[m_owner] && lock_i[m_owner] && m_run < MAX_LOCK - 1) begin
        nxt = m_owner;
      end else if (req_i[1] && m_wait == MAX_WAIT) begin
        nxt = 1;
      end else begin
        pos = (m_last_rr == 0) ? 0 : (m_last_rr == 2) ? 1 : 2;
        for (int k = 1; k <= 3; k++) begin
          cand = ring[(pos + k) % 3];
          if (nxt < 0 && req_i[cand]) begin
            nxt = cand;
            m_last_rr = cand;
          end
        end
        if (nxt < 0 && req_i[1]) nxt = 1;
      end
      m_run   = (nxt >= 0 && nxt == m_owner) ? m_run + 1 : 0;
      m_wait  = (!req_i[1] || nxt == 1) ? 0 : ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT);
      m_owner = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    drive(4'b0000, 4'b0000, 1'b1);
    tick();
  endtask

  task automatic test_reset();
    drive(4'b1111, 4'b1111, 1'b1);
    tick();
    n_vec++;
    if (grant_o !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b expected 0000", grant_o); end
    n_vec++;
    if (gnt_id_o !== 2'd0) begin n_err++; $display("FAIL reset_id: got %0d expected 0", gnt_id_o); end
    n_vec++;
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_single_m0();
    logic [3:0] exp_h;
    logic [3:0] exp_g;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0001, 4'b0000, 1'b0);
      exp_h = (i == 0) ? 4'b0001 : 4'b0000;
      exp_g = (i == 0) ? 4'b0000 : 4'b0001;
      n_vec++;
      if (hold_o !== exp_h) begin n_err++; $display("FAIL single_hold[%0d]: got %b expected %b", i, hold_o, exp_h); end
      n_vec++;
      if (grant_o !== exp_g) begin n_err++; $display("FAIL single_pre_grant[%0d]: got %b expected %b", i, grant_o, exp_g); end
      tick();
      n_vec++;
      if (grant_o !== 4'b0001 || gnt_id_o !== 2'd0) begin
        n_err++; $display("FAIL single_grant[%0d]: got %b/%0d expected 0001/0", i, grant_o, gnt_id_o);
      end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] seq[4] = '{4'b0001, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] ids[4] = '{2'd0, 2'd2, 2'd3, 2'd0};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(4'b1101, 4'b0000, 1'b0);
      tick();
      n_vec++;
      if (grant_o !== seq[i] || gnt_id_o !== ids[i]) begin
        n_err++; $display("FAIL rotation[%0d]: got %b/%0d expected %b/%0d", i, grant_o, gnt_id_o, seq[i], ids[i]);
      end
      n_vec++;
      if (grant_o !== exp_grant()) begin n_err++; $display("FAIL rotation_model[%0d]: got %b expected %b", i, grant_o, exp_grant()); end
    end
  endtask

  task automatic test_background_m1();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(4'b0010, 4'b0000, 1'b0);
      tick();
      n_vec++;
      if (grant_o !== 4'b0010 || gnt_id_o !== 2'd1 || busy_o !== 1'b1) begin
        n_err++; $display("FAIL background[%0d]: got %b/%0d/%b expected 0010/1/1", i, grant_o, gnt_id_o, busy_o);
      end
    end
  endtask

  task automatic test_starvation();
    int last_m1 = -1;
    int m1_cnt = 0;
    logic [3:0] exp_g;
    apply_reset();
    for (int t = 1; t <= 27; t++) begin
      drive(4'b0011, 4'b0000, 1'b0);
      tick();
      exp_g = (t % 9 == 0) ? 4'b0010 : 4'b0001;
      n_vec++;
      if (grant_o !== exp_g) begin n_err++; $display("FAIL starve[%0d]: got %b expected %b", t, grant_o, exp_g); end
      n_vec++;
      if (grant_o !== exp_grant()) begin n_err++; $display("FAIL starve_model[%0d]: got %b expected %b", t, grant_o, exp_grant()); end
      if (grant_o === 4'b0010) begin
        m1_cnt++;
        if (last_m1 >= 0) begin
          n_vec++;
          if (t - last_m1 != MAX_WAIT + 1) begin
            n_err++; $display("FAIL starve_period: got %0d expected %0d", t - last_m1, MAX_WAIT + 1);
          end
        end
        last_m1 = t;
      end
    end
    n_vec++;
    if (m1_cnt != 3) begin n_err++; $display("FAIL starve_count: got %0d expected 3", m1_cnt); end
  endtask

  task automatic test_lock_limit();
    int held = 0;
    logic [3:0] exp_g;
    apply_reset();
    drive(4'b0100, 4'b0100, 1'b0);
    tick();
    if (grant_o === 4'b0100) held = 1;
    for (int t = 2; t <= 17; t++) begin
      drive(4'b0101, 4'b0100, 1'b0);
      tick();
      exp_g = (t <= MAX_LOCK) ? 4'b0100 : 4'b0001;
      n_vec++;
      if (grant_o !== exp_g) begin n_err++; $display("FAIL lock[%0d]: got %b expected %b", t, grant_o, exp_g); end
      if (grant_o === 4'b0100 && held == t - 1) held = t;
    end
    n_vec++;
    if (held != MAX_LOCK) begin n_err++; $display("FAIL lock_length: got %0d expected %0d", held, MAX_LOCK); end
    n_vec++;
    if (grant_o !== exp_grant()) begin n_err++; $display("FAIL lock_model: got %b expected %b", grant_o, exp_grant()); end
  endtask

  task automatic test_reset_mid_lock();
    apply_reset();
    drive(4'b1000, 4'b1000, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(4'b1001, 4'b1000, 1'b0);
      tick();
      n_vec++;
      if (grant_o !== 4'b1000) begin n_err++; $display("FAIL midlock_hold[%0d]: got %b expected 1000", i, grant_o); end
    end
    drive(4'b1001, 4'b1000, 1'b1);
    tick();
    n_vec++;
    if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL midlock_reset: got %b/%b expected 0000/0", grant_o, busy_o);
    end
    drive(4'b1001, 4'b0000, 1'b0);
    tick();
    n_vec++;
    if (grant_o !== 4'b0001 || gnt_id_o !== 2'd0) begin
      n_err++; $display("FAIL midlock_rearb: got %b/%0d expected 0001/0", grant_o, gnt_id_o);
    end
  endtask

  task automatic test_random();
    logic [3:0] r = 4'b0000;
    logic [3:0] l = 4'b0000;
    logic       rst;
    logic [3:0] exp_h;
    apply_reset();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      if ($urandom_range(0, 3) == 0) l = 4'($urandom & $urandom);
      rst = ($urandom_range(0, 63) == 0);
      drive(r, l, rst);
      exp_h = r & ~exp_grant();
      n_vec++;
      if (hold_o !== exp_h) begin n_err++; $display("FAIL rand_hold[%0d]: got %b expected %b", i, hold_o, exp_h); end
      tick();
      n_vec++;
      if (grant_o !== exp_grant() || gnt_id_o !== exp_id() || busy_o !== (m_owner >= 0)) begin
        n_err++;
        $display("FAIL rand_grant[%0d]: got %b/%0d/%b expected %b/%0d/%b", i, grant_o, gnt_id_o, busy_o,
                 exp_grant(), exp_id(), (m_owner >= 0));
      end
      n_vec++;
      if ($countones(grant_o) > 1 || (grant_o & ~dec_req) !== 4'b0000) begin
        n_err++; $display("FAIL rand_invariant[%0d]: grant %b req %b", i, grant_o, dec_req);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    req_i  = 4'b0000;
    lock_i = 4'b0000;
    test_reset();
    test_single_m0();
    test_rotation();
    test_background_m1();
    test_starvation();
    test_lock_limit();
    test_reset_mid_lock();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xbus_arb.md
Name: xbus_arb

Overview:
- Request/grant arbiter for the four xbus masters:
  - m0: core load/store
  - m1: core instruction fetch
  - m2, m3: debug/download masters
- Decides which single master owns the bus each cycle and drives per-master hold back to the requesters.
- m0/m2/m3 share the bus round-robin. m1 (fetch) is the background owner, with anti-starvation forcing.
- Supports locked (multi-cycle) tenures with a bounded length.

Parameters:
- MAX_WAIT, 8: cycles m1 may be denied while requesting before it is force-granted (1..15).
- MAX_LOCK, 16: maximum consecutive cycles one master may retain the bus via lock (1..255).

Ports:
- clk  in  1: single clock, rising edge.
- rst_n  in  1: reset, synchronous and active-high; reset is asserted when rst_n=1.
- req_i  in  4: bit i = master i requests the bus this cycle.
- lock_i  in  4: bit i = master i wants to keep ownership next cycle; only meaningful with req_i[i].
- grant_o  out  4: registered one-hot grant; all-zero = bus idle.
- gnt_id_o  out  2: registered index of the granted master; 0 when idle.
- busy_o  out  1: registered; 1 when grant_o != 0.
- hold_o  out  4: combinational; hold_o[i] = req_i[i] & ~grant_o[i].

Behaviour:
- Reset, sampled at the clk edge with rst_n=1:
  - grant_o=0, gnt_id_o=0, busy_o=0.
  - rr_last=3, so m0 wins the first round-robin.
  - wait_cnt=0, lock_cnt=0.
  - Reset mid-tenure drops the grant at that edge; no tenure is retained.
- Latency: grant_next is computed combinationally from req_i, lock_i and internal state, and registered at the edge. A request first seen in cycle N is granted in cycle N+1 at the earliest.
- Decision order for grant_next (first match wins):
  1. Retain: current owner o has req_i[o]=1, lock_i[o]=1 and lock_cnt < MAX_LOCK-1 -> keep o.
  2. Starvation: req_i[1]=1 and wait_cnt == MAX_WAIT -> grant m1.
  3. Round-robin: among req_i[0], req_i[2], req_i[3], search in cyclic order 0->2->3->0, starting after rr_last -> grant the first requester found.
  4. Background: req_i[1]=1 -> grant m1.
  5. Otherwise -> grant none (idle).
- A lock whose owner drops req_i releases immediately; lock_i without req_i is ignored.
- State updates at each edge (when not in reset):
  - rr_last <= the granted index, only when the new grant goes to 0/2/3 via rule 3. Unchanged for retains and for m1 grants.
  - lock_cnt: increments by 1 if grant_next equals the current owner and both are non-idle; otherwise 0.
  - When lock_cnt would reach MAX_LOCK-1, rule 1 fails. The owner then competes normally: under rule 3 it is last in cyclic order, so any other requester wins.
  - wait_cnt <= 0 if req_i[1]=0 or grant_next=m1; otherwise wait_cnt+1, saturating at MAX_WAIT.
- Starvation rule 2 overrides new round-robin grants but not an active lock (rule 1). The forced m1 grant lasts one cycle unless m1 itself locks.
- Invariants:
  - grant_o is always zero- or one-hot.
  - A grant is never issued to a master whose req_i was 0 in the decision cycle.
  - gnt_id_o is consistent with grant_o.
- Simultaneous requests from all four masters with no locks:
  - Cycle sequence m0, m2, m3, m0, ...
  - m1 is served once wait_cnt saturates, then the rotation resumes.

Test Plan:
- Reset then req_i=4'b0001 for 3 cycles:
  - grant_o=0 in the first request cycle, 0001 on the next, gnt_id_o=0.
  - hold_o[0]=1 only in the first cycle.
- req_i=4'b1101 held, lock_i=0: grant sequence 0001, 0100, 1000, 0001 with gnt_id_o = 0, 2, 3, 0.
- req_i=4'b0010 only: grant_o=0010 from the second cycle and stays there, busy_o=1.
- req_i=4'b0011, MAX_WAIT=8, lock_i=0:
  - m0 granted continuously (it is the sole round-robin requester).
  - After wait_cnt reaches 8, grant_o=0010 for exactly one cycle, then 0001 again.
  - Verify the period.
- m2 with req=1, lock=1 and m0 also requesting, MAX_LOCK=16:
  - m2 keeps the grant for exactly 16 consecutive cycles.
  - m0 is granted on the 17th.
- Reset mid-lock (rst_n=1 for one cycle while m3 owns): grant_o=0 and busy_o=0 at that edge; on re-arbitration m0 wins over m3 (rr_last=3).
